// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - ordered release of N_OUT reset domains with software re-sequencing
//
// Purpose:
//   Takes the synchronized active-low system reset and releases the downstream
//   reset domains one at a time. Bit 0 goes first, HOLD_CYCLES edges after
//   reset negation. Each further bit follows GAP_CYCLES edges after the
//   previous one. Once every domain is out of reset, a level software request
//   sampled in RUN re-runs the whole sequence without a system reset.
//
// Optional feature (macro RESET_SEQ_REVERSE_ASSERT_EN):
//   undefined : an accepted software request drops every domain reset at once.
//   defined   : an accepted software request drops the domains in reverse
//               order, highest index first, GAP_CYCLES apart. The release
//               sequence then restarts from HOLD.
//
// Ports:
//   CLK_I       in   1      clock
//   NRST_I      in   1      async reset, active low (negation already synchronous to CLK_I)
//   SRST_REQ_I  in   1      software reset request, level, sampled on CLK_I
//   NRST_O      out  N_OUT  sequenced domain resets, active low
//   READY_O     out  1      high once every NRST_O bit is released
//   SRST_ACK_O  out  1      one-cycle pulse when a software request is accepted

module reset_sequencer #(
  parameter int N_OUT       = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 8
) (
  input  logic             CLK_I,
  input  logic             NRST_I,
  input  logic             SRST_REQ_I,
  output logic [N_OUT-1:0] NRST_O,
  output logic             READY_O,
  output logic             SRST_ACK_O
);

  // Counter sized for the longer of the two intervals. The width is clamped
  // to at least one bit so that elaboration reaches the parameter checks
  // below rather than failing on a zero-width vector.
  localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW_RAW  = $clog2(MAX_CYC + 1);
  localparam int CW      = (CW_RAW < 1) ? 1 : CW_RAW;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(MAX_CYC);

  localparam logic [1:0] ST_HOLD     = 2'd0;
  localparam logic [1:0] ST_RELEASE  = 2'd1;
  localparam logic [1:0] ST_RUN      = 2'd2;
`ifdef RESET_SEQ_REVERSE_ASSERT_EN
  localparam logic [1:0] ST_SWASSERT = 2'd3;
`endif

  if (N_OUT < 1) begin : g_bad_n_out
    $error("reset_sequencer: N_OUT must be >= 1");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("reset_sequencer: HOLD_CYCLES must be >= 1");
  end
  if (GAP_CYCLES < 1) begin : g_bad_gap
    $error("reset_sequencer: GAP_CYCLES must be >= 1");
  end

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_inc;
  logic [N_OUT-1:0] release_next;

  // The counter saturates instead of wrapping. The FSM restarts it before it
  // reaches CNT_MAX, so the guard only matters if the state is ever corrupted.
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);

  // Released bits form a contiguous run of ones starting at bit 0. Shifting a
  // one in at the bottom therefore releases the next domain in order.
  assign release_next = N_OUT'({NRST_O, 1'b1});

`ifdef RESET_SEQ_REVERSE_ASSERT_EN
  // Shifting right clears the highest released bit first.
  logic [N_OUT-1:0] assert_next;
  assign assert_next = NRST_O >> 1;
`endif

  always_ff @(posedge CLK_I or negedge NRST_I) begin
    if (!NRST_I) begin
      state      <= ST_HOLD;
      cnt        <= '0;
      NRST_O     <= '0;
      READY_O    <= 1'b0;
      SRST_ACK_O <= 1'b0;
    end else begin
      SRST_ACK_O <= 1'b0;
      case (state)
        ST_HOLD: begin
          // cnt holds (edge number - 1), so the match happens on edge HOLD_CYCLES.
          if (cnt == HOLD_LAST) begin
            NRST_O <= release_next;
            cnt    <= '0;
            state  <= ST_RELEASE;
          end else begin
            cnt <= cnt_inc;
          end
        end

        ST_RELEASE: begin
          // READY follows one edge after the final release. With N_OUT=1 that
          // is the first edge spent in RELEASE.
          if (&NRST_O) begin
            READY_O <= 1'b1;
            cnt     <= '0;
            state   <= ST_RUN;
          end else if (cnt == GAP_LAST) begin
            NRST_O <= release_next;
            cnt    <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end

        ST_RUN: begin
          if (SRST_REQ_I) begin
            SRST_ACK_O <= 1'b1;
            READY_O    <= 1'b0;
            cnt        <= '0;
`ifdef RESET_SEQ_REVERSE_ASSERT_EN
            // The highest domain drops on the accepting edge itself. A single
            // domain goes straight back to HOLD.
            NRST_O <= assert_next;
            state  <= (assert_next == '0) ? ST_HOLD : ST_SWASSERT;
`else
            NRST_O <= '0;
            state  <= ST_HOLD;
`endif
          end
        end

`ifdef RESET_SEQ_REVERSE_ASSERT_EN
        ST_SWASSERT: begin
          if (cnt == GAP_LAST) begin
            NRST_O <= assert_next;
            cnt    <= '0;
            if (assert_next == '0) begin
              state <= ST_HOLD;
            end
          end else begin
            cnt <= cnt_inc;
          end
        end
`endif

        default: begin
          state   <= ST_HOLD;
          cnt     <= '0;
          NRST_O  <= '0;
          READY_O <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed self-checking bench for reset_sequencer
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       nrst_a, req_a, nrst_b, req_b;
  logic [2:0] nrst_o_a;
  logic       ready_a, ack_a;
  logic [0:0] nrst_o_b;
  logic       ready_b, ack_b;

  int n_cmp = 0;
  int n_err = 0;
  int e     = 0;
  int acks  = 0;

  always #5 clk = ~clk;

  reset_sequencer #(.N_OUT(3), .HOLD_CYCLES(16), .GAP_CYCLES(8)) dut_a (
    .CLK_I(clk), .NRST_I(nrst_a), .SRST_REQ_I(req_a),
    .NRST_O(nrst_o_a), .READY_O(ready_a), .SRST_ACK_O(ack_a)
  );

  reset_sequencer #(.N_OUT(1), .HOLD_CYCLES(1), .GAP_CYCLES(1)) dut_b (
    .CLK_I(clk), .NRST_I(nrst_b), .SRST_REQ_I(req_b),
    .NRST_O(nrst_o_b), .READY_O(ready_b), .SRST_ACK_O(ack_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    e++;
  endtask

  // Power-on release pattern, k = edges since reset negation.
  function automatic logic [2:0] pon(input int k);
    if (k >= 32) return 3'b111;
    if (k >= 24) return 3'b011;
    if (k >= 16) return 3'b001;
    return 3'b000;
  endfunction

  // Pattern after a software request accepted k edges ago.
  function automatic logic [2:0] sw_nrst(input int k);
`ifdef RESET_SEQ_REVERSE_ASSERT_EN
    if (k < 8)  return 3'b011;
    if (k < 16) return 3'b001;
    return pon(k - 16);
`else
    return pon(k);
`endif
  endfunction

  function automatic logic sw_ready(input int k);
`ifdef RESET_SEQ_REVERSE_ASSERT_EN
    return (k - 16) >= 33;
`else
    return k >= 33;
`endif
  endfunction

  initial begin
    nrst_a = 1'b0; req_a = 1'b0;
    nrst_b = 1'b0; req_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_nrst", nrst_o_a, 3'b000);
    chk("rst_a_ready", ready_a, 1'b0);
    chk("rst_a_ack", ack_a, 1'b0);
    chk("rst_b_nrst_req_high", nrst_o_b, 1'b0);
    chk("rst_b_ready", ready_b, 1'b0);
    chk("rst_b_ack_req_high", ack_b, 1'b0);

    // Corner instance: N_OUT=1, HOLD=1, GAP=1.
    req_b = 1'b0;
    @(negedge clk); nrst_b = 1'b1; e = 0;
    step(); chk("b_e1_nrst", nrst_o_b, 1'b1); chk("b_e1_ready", ready_b, 1'b0);
    step(); chk("b_e2_nrst", nrst_o_b, 1'b1); chk("b_e2_ready", ready_b, 1'b1);
    chk("b_e2_ack", ack_b, 1'b0);
    // Request and reset asserted together: reset wins, no ACK.
    @(negedge clk); req_b = 1'b1; nrst_b = 1'b0; #1;
    chk("b_sim_nrst", nrst_o_b, 1'b0); chk("b_sim_ready", ready_b, 1'b0);
    chk("b_sim_ack", ack_b, 1'b0);
    step(); chk("b_sim_ack_next", ack_b, 1'b0); chk("b_sim_nrst_next", nrst_o_b, 1'b0);

    // Power-on sequence.
    @(negedge clk); nrst_a = 1'b1; e = 0;
    for (int i = 1; i <= 39; i++) begin
      step();
      chk($sformatf("pon_nrst_e%0d", e), nrst_o_a, pon(e));
      chk($sformatf("pon_ready_e%0d", e), ready_a, e >= 33);
      chk($sformatf("pon_ack_e%0d", e), ack_a, 1'b0);
    end

    // Software request sampled at edge 40 in RUN.
    req_a = 1'b1;
    for (int i = 40; i <= 95; i++) begin
      step();
      if (i == 40) req_a = 1'b0;
      chk($sformatf("sw_nrst_e%0d", e), nrst_o_a, sw_nrst(e - 40));
      chk($sformatf("sw_ready_e%0d", e), ready_a, sw_ready(e - 40));
      chk($sformatf("sw_ack_e%0d", e), ack_a, e == 40);
    end

    // Mid-sequence system reset between edges 20 and 21.
    @(negedge clk); nrst_a = 1'b0;
    @(negedge clk); nrst_a = 1'b1; e = 0;
    for (int i = 1; i <= 20; i++) step();
    chk("mid_pre_nrst", nrst_o_a, 3'b001);
    @(negedge clk); nrst_a = 1'b0; #1;
    chk("mid_nrst_immediate", nrst_o_a, 3'b000);
    chk("mid_ready_immediate", ready_a, 1'b0);
    step(); step();
    chk("mid_nrst_held", nrst_o_a, 3'b000);
    @(negedge clk); nrst_a = 1'b1; e = 0;
    for (int i = 1; i <= 34; i++) begin
      step();
      chk($sformatf("mid_nrst_e%0d", e), nrst_o_a, pon(e));
      chk($sformatf("mid_ready_e%0d", e), ready_a, e >= 33);
    end

    // Request outside RUN is ignored; a held request is taken once RUN is reached.
    @(negedge clk); nrst_a = 1'b0;
    @(negedge clk); nrst_a = 1'b1; e = 0;
    for (int i = 1; i <= 32; i++) begin
      if (i == 20 || i >= 25) req_a = 1'b1;
      step();
      if (i == 20) req_a = 1'b0;
      chk($sformatf("ign_nrst_e%0d", e), nrst_o_a, pon(e));
      chk($sformatf("ign_ack_e%0d", e), ack_a, 1'b0);
    end
    acks = 0;
    for (int i = 33; i <= 36; i++) begin
      step();
      if (i == 34) req_a = 1'b0;
      acks += int'(ack_a);
    end
    chk("held_req_ack_count", acks, 1);
    chk("held_req_ready_low", ready_a, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
